// File: rtl/kamus_pkg.sv
// Shared types for the kamus instruction-fetch front end.
//   fetch_state_e          : fetch controller FSM states
//   instr_addr_sel_state_e : source of the next fetch pc
//   fetch_entry_t          : {instruction, pc} word held by the output/skid registers
package kamus_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_e;

    typedef enum logic [1:0] {
        ADDR_SEL_KEEP,
        ADDR_SEL_SEQ,
        ADDR_SEL_REDIRECT
    } instr_addr_sel_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force word alignment of a jump/branch target.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/kamus_fetch_ctrl.sv
// Instruction fetch controller: issues one L1I request at a time, buffers the
// returned word in an output register (plus a one-entry skid) toward ID, and
// handles EX redirects by flushing buffered words and killing in-flight data.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   fetch_en_i                    level enable for new requests
//   id_stall_i                    ID cannot take the presented word
//   ex_redirect_i, ex_target_i    redirect pulse and target pc
//   l1i_req_o, l1i_addr_o         request / address to L1I (addr = internal pc)
//   l1i_gnt_i                     L1I accepted the request
//   l1i_rvalid_i, l1i_rdata_i     L1I response for the outstanding request
//   id_valid_o, id_instr_o, id_pc_o  word presented to ID
//   flush_o                       IF/ID kill, same-cycle copy of ex_redirect_i
module kamus_fetch_ctrl
    import kamus_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fetch_en_i,
    input  logic            id_stall_i,
    input  logic            ex_redirect_i,
    input  logic [XLEN-1:0] ex_target_i,
    output logic            l1i_req_o,
    output logic [XLEN-1:0] l1i_addr_o,
    input  logic            l1i_gnt_i,
    input  logic            l1i_rvalid_i,
    input  logic [ILEN-1:0] l1i_rdata_i,
    output logic            id_valid_o,
    output logic [ILEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic            flush_o
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    fetch_state_e          w_resume_state;
    logic                  r_kill;
    logic                  w_kill_nxt;
    logic [XLEN-1:0]       r_pc;
    logic                  r_out_valid;
    fetch_entry_t          r_out;
    fetch_entry_t          r_skid;
    fetch_entry_t          w_rsp_entry;
    logic                  w_consume;
    logic                  w_req;
    logic                  w_out_load_rsp;
    logic                  w_out_load_skid;
    logic                  w_skid_load;
    instr_addr_sel_state_e w_pc_sel;

    assign w_consume      = r_out_valid & ~id_stall_i;
    assign w_resume_state = fetch_en_i ? FS_REQ : FS_IDLE;
    // pc already advanced on grant, so the in-flight word belongs to pc - 4.
    assign w_rsp_entry    = '{instr: l1i_rdata_i, pc: r_pc - PC_STEP};

    // State and kill-flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= FS_IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    // Next-state, request and buffer-control decode; redirect overrides all.
    always_comb begin
        w_state_nxt     = r_state;
        w_kill_nxt      = r_kill;
        w_req           = 1'b0;
        w_out_load_rsp  = 1'b0;
        w_out_load_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_pc_sel        = ADDR_SEL_KEEP;

        unique case (r_state)
            FS_IDLE: begin
                if (fetch_en_i) w_state_nxt = FS_REQ;
            end
            FS_REQ: begin
                w_req = fetch_en_i & ~(r_out_valid & id_stall_i);
                if (w_req && l1i_gnt_i) begin
                    w_pc_sel    = ADDR_SEL_SEQ;
                    w_state_nxt = FS_WAIT;
                end else if (!fetch_en_i) begin
                    w_state_nxt = FS_IDLE;
                end
            end
            FS_WAIT: begin
                if (l1i_rvalid_i) begin
                    w_state_nxt = w_resume_state;
                    if (r_kill) begin
                        w_kill_nxt = 1'b0;
                    end else if (!r_out_valid || !id_stall_i) begin
                        w_out_load_rsp = 1'b1;
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_nxt = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (w_consume) begin
                    w_out_load_skid = 1'b1;
                    w_state_nxt     = w_resume_state;
                end
            end
            default: w_state_nxt = FS_IDLE;
        endcase

        if (ex_redirect_i) begin
            w_out_load_rsp  = 1'b0;
            w_out_load_skid = 1'b0;
            w_skid_load     = 1'b0;
            w_pc_sel        = ADDR_SEL_REDIRECT;
            w_kill_nxt      = 1'b0;
            unique case (r_state)
                FS_IDLE: w_state_nxt = FS_IDLE;
                FS_REQ: begin
                    // A grant in the redirect cycle leaves stale data in flight.
                    if (w_req && l1i_gnt_i) begin
                        w_state_nxt = FS_WAIT;
                        w_kill_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = FS_REQ;
                    end
                end
                FS_WAIT: begin
                    // Stale data arriving this very cycle is simply dropped.
                    if (l1i_rvalid_i) begin
                        w_state_nxt = FS_REQ;
                    end else begin
                        w_state_nxt = FS_WAIT;
                        w_kill_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = FS_REQ;
            endcase
        end
    end

    // pc, output register and skid register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc        <= BOOT_ADDR;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_skid      <= '0;
        end else begin
            case (w_pc_sel)
                ADDR_SEL_SEQ:      r_pc <= r_pc + PC_STEP;
                ADDR_SEL_REDIRECT: r_pc <= align_pc(ex_target_i);
                default:           r_pc <= r_pc;
            endcase

            if (ex_redirect_i) begin
                r_out_valid <= 1'b0;
                r_out       <= '0;
                r_skid      <= '0;
            end else begin
                if (w_out_load_rsp) begin
                    r_out_valid <= 1'b1;
                    r_out       <= w_rsp_entry;
                end else if (w_out_load_skid) begin
                    r_out_valid <= 1'b1;
                    r_out       <= r_skid;
                end else if (w_consume) begin
                    r_out_valid <= 1'b0;
                end
                if (w_skid_load) r_skid <= w_rsp_entry;
            end
        end
    end

    assign l1i_req_o  = w_req;
    assign l1i_addr_o = r_pc;
    assign id_valid_o = r_out_valid;
    assign id_instr_o = r_out.instr;
    assign id_pc_o    = r_out.pc;
    assign flush_o    = ex_redirect_i;

endmodule

// File: tb/tb_kamus_fetch_ctrl.sv
// Bench for kamus_fetch_ctrl: the bench plays L1I (one outstanding request,
// random grant/latency) and the EX/ID neighbours. Delivered words are checked
// against an ordered scoreboard built from program-order rules: every grant
// must carry the next sequential pc since the last reset/redirect, and every
// response not superseded by a redirect/reset must reach ID exactly once, in order.
module tb_kamus_fetch_ctrl;

    localparam logic [31:0] BOOT = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        fetch_en_i = 1'b0;
    logic        id_stall_i = 1'b0;
    logic        ex_redirect_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        l1i_req_o;
    logic [31:0] l1i_addr_o;
    logic        l1i_gnt_i = 1'b0;
    logic        l1i_rvalid_i = 1'b0;
    logic [31:0] l1i_rdata_i = '0;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        flush_o;

    kamus_fetch_ctrl #(.BOOT_ADDR(BOOT)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fetch_en_i   (fetch_en_i),
        .id_stall_i   (id_stall_i),
        .ex_redirect_i(ex_redirect_i),
        .ex_target_i  (ex_target_i),
        .l1i_req_o    (l1i_req_o),
        .l1i_addr_o   (l1i_addr_o),
        .l1i_gnt_i    (l1i_gnt_i),
        .l1i_rvalid_i (l1i_rvalid_i),
        .l1i_rdata_i  (l1i_rdata_i),
        .id_valid_o   (id_valid_o),
        .id_instr_o   (id_instr_o),
        .id_pc_o      (id_pc_o),
        .flush_o      (flush_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } pend_t;

    item_t       exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] gnt_log[$];
    int unsigned epoch = 0;
    logic [31:0] exp_addr = BOOT;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    int unsigned k_gnt_pct = 100, k_rv_min = 1, k_rv_max = 1;
    int unsigned k_stall_pct = 0, k_redir_pct = 0, k_spur_pct = 0, k_en_pct = 100;
    logic        f_stall_en = 1'b0, f_stall = 1'b0;
    int          f_redir_mode = 0;   // 0 none, 1 this cycle, 2 on next grant
    logic [31:0] f_target = '0;
    logic        lat_expect = 1'b0;
    logic [31:0] lat_pc = '0;
    logic        last_gnt = 1'b0;
    logic [31:0] last_gnt_addr = '0;
    item_t       mon_e;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // One bus cycle: drive at negedge, settle, grant/redirect, update the model.
    task automatic step();
        logic  stall, rv, real_rv, gnt, redir;
        logic  [31:0] tgt;
        pend_t p;
        item_t e;
        int    n_before;
        @(negedge clk_i);
        if (lat_expect) begin
            check("rvalid_to_id_valid", 32'(id_valid_o), 32'd1);
            check("rvalid_to_id_pc", id_pc_o, lat_pc);
            lat_expect = 1'b0;
        end
        stall = f_stall_en ? f_stall : ($urandom_range(99) < k_stall_pct);
        fetch_en_i = ($urandom_range(99) < k_en_pct);
        rv = 1'b0;
        real_rv = 1'b0;
        p = '{addr: '0, epoch: 0, due: 0};
        if (pend_q.size() != 0 && cyc >= pend_q[0].due) begin
            p = pend_q.pop_front();
            rv = 1'b1;
            real_rv = 1'b1;
            l1i_rdata_i = mem(p.addr);
        end else begin
            rv = (pend_q.size() == 0) && ($urandom_range(99) < k_spur_pct);
            l1i_rdata_i = $urandom();
        end
        id_stall_i = stall;
        l1i_rvalid_i = rv;
        l1i_gnt_i = 1'b0;
        ex_redirect_i = 1'b0;
        #1;
        if (exp_q.size() >= 2 || (exp_q.size() != 0 && stall))
            check("req_blocked", 32'(l1i_req_o), 32'd0);
        if (l1i_req_o) begin
            check("req_addr", l1i_addr_o, exp_addr);
            check("one_outstanding", 32'(pend_q.size()), 32'd0);
        end
        gnt = l1i_req_o && ($urandom_range(99) < k_gnt_pct);
        redir = (f_redir_mode == 1) || (f_redir_mode == 2 && gnt) || ($urandom_range(99) < k_redir_pct);
        tgt = (f_redir_mode != 0) ? f_target : $urandom();
        if (f_redir_mode == 1 || (f_redir_mode == 2 && gnt)) f_redir_mode = 0;
        l1i_gnt_i = gnt;
        ex_redirect_i = redir;
        ex_target_i = tgt;
        #1;
        check("flush", 32'(flush_o), 32'(redir));
        last_gnt = gnt;
        n_before = exp_q.size();
        if (real_rv && p.epoch == epoch && !redir) begin
            e.pc = p.addr;
            e.instr = mem(p.addr);
            exp_q.push_back(e);
            if (n_before == 0 || !stall) begin
                lat_expect = 1'b1;
                lat_pc = p.addr;
            end
        end
        if (gnt) begin
            last_gnt_addr = l1i_addr_o;
            gnt_log.push_back(l1i_addr_o);
            pend_q.push_back('{addr: l1i_addr_o, epoch: epoch,
                               due: cyc + $urandom_range(k_rv_max, k_rv_min)});
            exp_addr = exp_addr + 32'd4;
        end
        if (redir) begin
            epoch++;
            exp_q.delete();
            exp_addr = {tgt[31:2], 2'b00};
            lat_expect = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        l1i_gnt_i = 1'b0;
        l1i_rvalid_i = 1'b0;
        ex_redirect_i = 1'b0;
        id_stall_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        check("rst_req", 32'(l1i_req_o), 32'd0);
        check("rst_valid", 32'(id_valid_o), 32'd0);
        check("rst_instr", id_instr_o, 32'd0);
        check("rst_pc", id_pc_o, 32'd0);
        check("rst_addr", l1i_addr_o, BOOT);
        check("rst_flush", 32'(flush_o), 32'd0);
        exp_q.delete();
        epoch++;
        exp_addr = BOOT;
        lat_expect = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic wait_gnt(input string name, output logic [31:0] a);
        bit ok;
        ok = 1'b0;
        a = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (last_gnt) begin
                ok = 1'b1;
                a = last_gnt_addr;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic wait_valid(input string name, output logic [31:0] pc);
        bit ok;
        ok = 1'b0;
        pc = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (id_valid_o) begin
                ok = 1'b1;
                pc = id_pc_o;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    // Monitor: each word consumed by ID must be the oldest expected word.
    initial begin
        forever begin
            @(negedge clk_i);
            #3;
            if (rst_ni && id_valid_o && !id_stall_i && !ex_redirect_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h instr %h expected no word", id_pc_o, id_instr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_pc", id_pc_o, mon_e.pc);
                    check("sb_instr", id_instr_o, mon_e.instr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] held;
        bit          have;
        bit          done;

        do_reset();

        // Back-to-back fetch, grant same cycle, data next cycle.
        gnt_log.delete();
        repeat (10) step();
        if (gnt_log.size() >= 3) begin
            a = gnt_log[0]; check("seq_addr0", a, 32'h0);
            a = gnt_log[1]; check("seq_addr1", a, 32'h4);
            a = gnt_log[2]; check("seq_addr2", a, 32'h8);
        end else begin
            timeout_fail("seq_grants");
        end

        // ID stall with a fetch in flight: word held, no new request, no loss.
        k_rv_min = 3; k_rv_max = 3;
        wait_gnt("stall_setup", a);
        f_stall_en = 1'b1; f_stall = 1'b1; have = 1'b0; held = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (id_valid_o) begin
                if (!have) begin
                    held = id_instr_o;
                    have = 1'b1;
                end else begin
                    check("stall_instr_stable", id_instr_o, held);
                    check("stall_req_low", 32'(l1i_req_o), 32'd0);
                end
            end
        end
        check("stall_word_held", 32'(id_valid_o), 32'd1);
        f_stall_en = 1'b0;

        // Redirect to 0x100 while waiting for data.
        wait_gnt("redir_wait_setup", a);
        f_redir_mode = 1; f_target = 32'h100;
        step();
        wait_gnt("redir_wait_gnt", a);
        check("redir_wait_addr", a, 32'h100);
        wait_valid("redir_wait_valid", a);
        check("redir_wait_id_pc", a, 32'h100);

        // Redirect to 0x203 on the grant cycle: stale data killed, fetch 0x200.
        k_rv_min = 1; k_rv_max = 1;
        f_redir_mode = 2; f_target = 32'h203;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            done = (f_redir_mode == 0);
        end
        if (!done) timeout_fail("redir_gnt_setup");
        wait_gnt("redir_gnt_gnt", a);
        check("redir_gnt_addr", a, 32'h200);
        wait_valid("redir_gnt_valid", a);
        check("redir_gnt_id_pc", a, 32'h200);

        // pc wrap at the top of the address space.
        f_redir_mode = 1; f_target = 32'hFFFF_FFF8;
        step();
        gnt_log.delete();
        for (int i = 0; i < 3; i++) wait_gnt("wrap_gnt", a);
        if (gnt_log.size() >= 3) begin
            a = gnt_log[0]; check("wrap_addr0", a, 32'hFFFF_FFF8);
            a = gnt_log[1]; check("wrap_addr1", a, 32'hFFFF_FFFC);
            a = gnt_log[2]; check("wrap_addr2", a, 32'h0);
        end

        // Reset while waiting, then a late response that must be ignored.
        k_rv_min = 5; k_rv_max = 5;
        wait_gnt("rst_wait_setup", a);
        do_reset();
        k_en_pct = 0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            step();
            done = (pend_q.size() == 0);
        end
        if (!done) timeout_fail("rst_late_rvalid");
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_late_valid_low", 32'(id_valid_o), 32'd0);
        end
        k_en_pct = 100; k_rv_min = 1; k_rv_max = 1;
        wait_gnt("rst_restart", a);
        check("rst_restart_addr", a, BOOT);

        // Randomised traffic.
        for (int blk = 0; blk < 15; blk++) begin
            k_gnt_pct   = $urandom_range(100, 30);
            k_rv_min    = 1;
            k_rv_max    = $urandom_range(4, 1);
            k_stall_pct = $urandom_range(60, 0);
            k_redir_pct = $urandom_range(5, 0);
            k_spur_pct  = $urandom_range(15, 0);
            k_en_pct    = $urandom_range(100, 70);
            repeat (200) step();
        end

        // Drain everything still buffered.
        k_stall_pct = 0; k_redir_pct = 0; k_spur_pct = 0; k_en_pct = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            done = (pend_q.size() == 0) && (exp_q.size() == 0);
        end
        if (!done) timeout_fail("drain");
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kamus_fetch_ctrl.md
KAMUS_FETCH_CTRL -- requirements
Module: kamus_fetch_ctrl

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0, SHALL be the first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 fetch_en_i  in  1  fetch enable; level-sensitive.
REQ-005 id_stall_i  in  1  ID cannot accept an instruction this cycle.
REQ-006 ex_redirect_i  in  1  one-cycle pulse: branch taken or jump resolved in EX.
REQ-007 ex_target_i  in  32  redirect target PC, valid with ex_redirect_i.
REQ-008 l1i_req_o  out  1  fetch request to L1I.
REQ-009 l1i_addr_o  out  32  fetch address, equal to the internal pc.
REQ-010 l1i_gnt_i  in  1  L1I accepts the request this cycle.
REQ-011 l1i_rvalid_i  in  1  L1I returns data for the oldest granted request.
REQ-012 l1i_rdata_i  in  32  returned instruction word.
REQ-013 id_valid_o  out  1  id_instr_o and id_pc_o are valid.
REQ-014 id_instr_o  out  32  instruction presented to ID.
REQ-015 id_pc_o  out  32  address of id_instr_o.
REQ-016 flush_o  out  1  kill IF/ID contents; combinational copy of ex_redirect_i.

Function
REQ-017 FSM states SHALL be FS_IDLE, FS_REQ, FS_WAIT and FS_HOLD, with at most one granted request outstanding.
REQ-018 FS_IDLE: l1i_req_o=0; fetch_en_i=1 SHALL move to FS_REQ on the next edge.
REQ-019 FS_REQ: l1i_req_o SHALL be 1 unless (id_valid_o & id_stall_i); req/addr SHALL hold stable until gnt; on gnt, pc += 4 (32-bit wrap: 32'hFFFF_FFFC -> 32'h0) and the FSM SHALL move to FS_WAIT.
REQ-020 FS_WAIT: on rvalid, if the output register is empty or consumed this cycle (id_valid_o & ~id_stall_i), it SHALL load {1, rdata, fetched pc} at that edge (1-cycle latency rvalid->id_valid_o) and the FSM SHALL return to FS_REQ; otherwise rdata/pc SHALL be stored in a one-entry skid register and the FSM SHALL go to FS_HOLD.
REQ-021 FS_HOLD: l1i_req_o=0; when the output register is consumed, the skid entry SHALL move into it and the FSM SHALL go to FS_REQ.
REQ-022 The output register SHALL hold its value while id_stall_i=1 and SHALL clear id_valid_o on consumption when no new data loads.
REQ-023 ex_redirect_i SHALL have priority over stall and all other events: flush_o=1 in the same cycle; at the next edge, the output and skid registers are cleared, pc <= {ex_target_i[31:2], 2'b00}, and the FSM goes to FS_REQ (FS_IDLE keeps its state but updates pc).
REQ-024 A redirect in FS_WAIT, or in FS_REQ coinciding with gnt, SHALL set a kill flag; the FSM SHALL stay in or enter FS_WAIT, the matching rvalid data SHALL be discarded, the kill flag SHALL clear, and the FSM SHALL then go to FS_REQ with the redirect pc.
REQ-025 fetch_en_i=0 SHALL stop new requests; an outstanding request SHALL complete normally, then the FSM SHALL go to FS_IDLE with pc retained.
REQ-026 rvalid while no request is outstanding SHALL be ignored.

Reset
REQ-027 On rst_ni=0, asynchronously: state=FS_IDLE, pc=BOOT_ADDR, kill=0, skid cleared, and l1i_req_o, id_valid_o, id_instr_o, id_pc_o all 0; l1i_addr_o=BOOT_ADDR; flush_o follows ex_redirect_i.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; the first rvalid after reset SHALL be ignored per REQ-026.

Structure
REQ-029 fetch_state_e SHALL be defined in kamus_pkg alongside instr_addr_sel_state_e.
REQ-030 The block SHALL be a single module with no sub-modules; the skid register SHALL be inline.

Verification
REQ-031 Reset then fetch_en_i=1, with gnt same cycle and rvalid the next cycle, no stall -> addresses 0x0, 0x4, 0x8; id_pc_o sequence 0x0, 0x4, 0x8, each valid one cycle after its rvalid.
REQ-032 id_stall_i=1 for 5 cycles with a fetch outstanding -> FS_HOLD entered, l1i_req_o=0, id_instr_o stable; after release, the skid word appears next with no loss or duplication.
REQ-033 ex_redirect_i with target 0x100 while in FS_WAIT -> flush_o=1 same cycle, the stale rdata is discarded, the next l1i_addr_o is 0x100, and the next id_pc_o is 0x100.
REQ-034 Redirect to 0x203 coincident with gnt -> the stale response is killed and the fetch address is 0x200.
REQ-035 Start with BOOT_ADDR=32'hFFFF_FFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, then 0x0.
REQ-036 rst_ni low while in FS_WAIT, then a late rvalid -> all outputs are 0 immediately, id_valid_o stays 0, and fetch restarts at BOOT_ADDR.
